maxpool2d: RTL and testbench
============================

# maxpool2d

Streaming 2x2, stride-2 signed max-pooling stage that sits directly downstream of `conv2d`. It consumes the raster-ordered convolution results, one per valid/ready transfer, and emits one maximum per non-overlapping 2x2 window, also in raster order. It buffers half a line of partial maxima internally and uses the same single-register elastic handshake as `conv2d`, so the two stages chain without glue logic.

## Interface
- `LineWidthPx`, 158: pixels per input line, equal to the conv2d output width (160-3+1); must be ≥ 2.
- `LineCountPx`, 118: lines per input frame; must be ≥ 2.
- `Width`, 32: signed sample width, equal to conv2d `WidthOut`.
- `clk_i` input 1: the only clock; all logic updates on the rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `valid_i` input 1: upstream sample valid.
- `ready_o` output 1: block can accept a sample.
- `data_i` input `Width`: signed input sample.
- `valid_o` output 1: pooled result valid.
- `ready_i` input 1: downstream can accept a result.
- `data_o` output `Width`: signed pooled result.

## Operation
- `in_fire = valid_i & ready_o`.
- `x_pos` and `y_pos` are raster counters, each at least `$clog2` wide with a minimum of 1 bit.
  - They advance only on `in_fire`.
  - `x_pos` wraps at `LineWidthPx-1`.
  - `y_pos` increments on the `x_pos` wrap and itself wraps to 0 after `LineCountPx-1`. Frames are back-to-back with no gap.
- Pair register `pair_r`:
  - On `in_fire` with even `x_pos`, `pair_r <= data_i`.
  - On odd `x_pos`, the pair maximum is `hmax = max(pair_r, data_i)`, a signed compare.
- Line buffer `lbuf`: `LineWidthPx/2` entries of `Width` bits, indexed by `x_pos>>1`.
  - Even `y_pos`, odd `x_pos`: `lbuf[x_pos>>1] <= hmax`.
  - Odd `y_pos`, odd `x_pos`: `result = max(lbuf[x_pos>>1], hmax)`, and a result is produced.
- `produce = in_fire & x_pos[0] & y_pos[0] & (x_pos>>1 < LineWidthPx/2) & (y_pos>>1 < LineCountPx/2)`.
- Odd trailing boundaries:
  - A trailing column (x = `LineWidthPx-1` with `LineWidthPx` odd) is accepted and discarded.
  - A trailing row (y = `LineCountPx-1` with `LineCountPx` odd) is accepted and discarded.
  - Neither may corrupt `lbuf` or `pair_r` state used by the next frame.
- Output frame is `LineWidthPx/2` x `LineCountPx/2` results (integer division).
- All compares are signed two's-complement. No arithmetic widening occurs; `data_o` is exactly one of the input samples, or 0 in the RELU case.
- Elastic output register:
  - `valid_r` resets to 0. When `ready_o`, `valid_r <= produce`.
  - `data_r` loads `result` when `produce`.
  - `ready_o = ~valid_r | ready_i`.
  - `valid_o = valid_r`, `data_o = data_r`.
- Reset values: `valid_o = 0`, `data_o = 0`, `ready_o = 1`, counters = 0, `pair_r = 0`. `lbuf` is not cleared, because every entry is written before it is read.

## Timing
- Latency: a result appears on `valid_o` the cycle after the `in_fire` of the bottom-right sample of its window.
- Throughput: one input per cycle when `ready_i` is held high. Results occur on at most one input cycle in four on average.
- Backpressure:
  - With `valid_o=1` and `ready_i=0`: `ready_o=0`, no input is accepted, and `valid_o`/`data_o` are held stable.
  - With `valid_o=1` and `ready_i=1` in the same cycle: a new input may fire, and the register is reloaded from `produce`, so no bubble is inserted.
- `ready_o` depends combinationally on `ready_i`. This matches conv2d, and the combined chain must still close timing.
- `rst_i` asserted mid-frame: on the next edge, counters, `valid_r` and `pair_r` clear, and the next accepted sample is treated as pixel (0,0). Any pending output is dropped.
- `valid_i` may drop at any point. State advances only on `in_fire`.

## Configuration
- `MAXPOOL2D_RELU_EN`:
  - When defined, each `data_i` is clamped as `(data_i < 0) ? 0 : data_i` before entering the pair/line-buffer datapath, so every `data_o` is ≥ 0. This fuses ReLU before the pool.
  - When undefined, samples pass unmodified and negative maxima are emitted.
  - Handshake and latency are identical in both builds.

## Test plan
- **4x4 ramp, build without RELU:** `LineWidthPx=4`, `LineCountPx=4`, input 0..15 with `ready_i=1` → outputs 5, 7, 13, 15, each valid one cycle after inputs 5, 7, 13 and 15 fire.
- **All-negative 4x4, values -16..-1, both builds:** without RELU → -11, -9, -3, -1; with `MAXPOOL2D_RELU_EN` → 0, 0, 0, 0.
- **5x5 odd dimensions, input 0..24:** outputs 6, 8, 16, 18. Column 4 and row 4 produce nothing. A second 5x5 frame sent back-to-back yields the same four values.
- **Backpressure on 4x4 ramp:** hold `ready_i=0` while `valid_o=1` → `ready_o=0` and `data_o` stays 5; release → all outputs arrive in order, none lost or duplicated.
- **Reset mid-frame:** assert `rst_i` after 6 inputs of a 4x4 frame, then send a fresh 0..15 frame → outputs exactly 5, 7, 13, 15.
- **Random stimulus:** random valid/ready on a 158x118 frame of random signed values against a reference model → exact match on sequence and count (79x59 results).

Source files
------------

// File: rtl/maxpool2d.sv
// Streaming 2x2 / stride-2 signed max-pool with a half-line buffer of partial maxima.
// Optional fused ReLU on the input samples when MAXPOOL2D_RELU_EN is defined.
module maxpool2d #(
  parameter int LineWidthPx = 158,
  parameter int LineCountPx = 118,
  parameter int Width       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  localparam int HalfW = LineWidthPx / 2;
  localparam int HalfH = LineCountPx / 2;
  localparam int XW    = (LineWidthPx > 2) ? $clog2(LineWidthPx) : 1;
  localparam int YW    = (LineCountPx > 2) ? $clog2(LineCountPx) : 1;
  localparam int AW    = (HalfW > 1) ? $clog2(HalfW) : 1;

  logic [XW-1:0]           x_pos_r;
  logic [YW-1:0]           y_pos_r;
  logic signed [Width-1:0] pair_r;
  logic signed [Width-1:0] data_r;
  logic                    valid_r;
  logic signed [Width-1:0] lbuf_r [HalfW];

  logic signed [Width-1:0] sample_s;
  logic signed [Width-1:0] hmax_s;
  logic signed [Width-1:0] lbuf_rd_s;
  logic signed [Width-1:0] result_s;
  logic [AW-1:0]           lbuf_idx_s;
  logic                    in_fire_s;
  logic                    produce_s;
  logic                    col_ok_s;
  logic                    row_ok_s;
  logic                    x_last_s;
  logic                    y_last_s;

  assign ready_o = ~valid_r | ready_i;
  assign valid_o = valid_r;
  assign data_o  = data_r;

  // Input conditioning: optional ReLU clamp ahead of the pooling datapath
  always_comb begin
`ifdef MAXPOOL2D_RELU_EN
    sample_s = data_i[Width-1] ? {Width{1'b0}} : data_i;
`else
    sample_s = data_i;
`endif
  end

  // Window position decode and the two-stage signed maximum
  always_comb begin
    in_fire_s  = valid_i & ready_o;
    x_last_s   = (x_pos_r == XW'(LineWidthPx - 1));
    y_last_s   = (y_pos_r == YW'(LineCountPx - 1));
    // Trailing odd column/row fall outside every window and must leave state untouched.
    col_ok_s   = ((int'(x_pos_r) >> 1) < HalfW);
    row_ok_s   = ((int'(y_pos_r) >> 1) < HalfH);
    lbuf_idx_s = AW'(x_pos_r >> 1);
    lbuf_rd_s  = lbuf_r[lbuf_idx_s];
    hmax_s     = (sample_s > pair_r) ? sample_s : pair_r;
    result_s   = (lbuf_rd_s > hmax_s) ? lbuf_rd_s : hmax_s;
    produce_s  = in_fire_s & x_pos_r[0] & y_pos_r[0] & col_ok_s & row_ok_s;
  end

  // Raster position counters, advancing only on accepted samples
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_pos_r <= {XW{1'b0}};
      y_pos_r <= {YW{1'b0}};
    end else if (in_fire_s) begin
      if (x_last_s) begin
        x_pos_r <= {XW{1'b0}};
        y_pos_r <= y_last_s ? {YW{1'b0}} : y_pos_r + YW'(1'b1);
      end else begin
        x_pos_r <= x_pos_r + XW'(1'b1);
      end
    end
  end

  // Left sample of each horizontal pair
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pair_r <= {Width{1'b0}};
    end else if (in_fire_s & ~x_pos_r[0] & col_ok_s) begin
      pair_r <= sample_s;
    end
  end

  // Top-row pair maxima; every entry is written before its matching read
  always_ff @(posedge clk_i) begin
    if (!rst_i && in_fire_s && x_pos_r[0] && !y_pos_r[0] && col_ok_s && row_ok_s) begin
      lbuf_r[lbuf_idx_s] <= hmax_s;
    end
  end

  // Single-register elastic output stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= 1'b0;
      data_r  <= {Width{1'b0}};
    end else if (ready_o) begin
      valid_r <= produce_s;
      if (produce_s) begin
        data_r <= result_s;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2d.sv
// Bench for maxpool2d: three instances (4x4, 5x5, 158x118) checked against a window-level model.
module tb_maxpool2d;

  localparam int NK = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        vin;
  logic [2:0]        rdy_in;
  logic [2:0][31:0]  din;
  logic              ro0, ro1, ro2, vo0, vo1, vo2;
  logic [31:0]       do0, do1, do2;
  logic [2:0]        rdy_out;
  logic [2:0]        vout;
  logic [2:0][31:0]  dout;

  assign rdy_out = {ro2, ro1, ro0};
  assign vout    = {vo2, vo1, vo0};
  assign dout    = {do2, do1, do0};

  always #5 clk = ~clk;

  maxpool2d #(.LineWidthPx(4), .LineCountPx(4), .Width(32)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(vin[0]), .ready_o(ro0), .data_i(din[0]),
    .valid_o(vo0), .ready_i(rdy_in[0]), .data_o(do0));
  maxpool2d #(.LineWidthPx(5), .LineCountPx(5), .Width(32)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(vin[1]), .ready_o(ro1), .data_i(din[1]),
    .valid_o(vo1), .ready_i(rdy_in[1]), .data_o(do1));
  maxpool2d #(.LineWidthPx(158), .LineCountPx(118), .Width(32)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(vin[2]), .ready_o(ro2), .data_i(din[2]),
    .valid_o(vo2), .ready_i(rdy_in[2]), .data_o(do2));

  int n_checks = 0;
  int n_errors = 0;
  int exp_q [NK][$];
  int got_q [NK][$];
  int row_buf [NK][2][158];
  int mx [NK];
  int my [NK];
  bit expect_next [NK];
  bit prev_hold [NK];
  int prev_data [NK];

  function automatic int lw_of(int k);
    case (k)
      0: return 4;
      1: return 5;
      default: return 158;
    endcase
  endfunction

  function automatic int lc_of(int k);
    case (k)
      0: return 4;
      1: return 5;
      default: return 118;
    endcase
  endfunction

  function automatic int relu(int v);
`ifdef MAXPOOL2D_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int gen(int mode, int i);
    case (mode)
      0: return i;
      1: return i - 16;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic chk(string name, logic signed [31:0] got, logic signed [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Model and compare: each completed 2x2 window queues its maximum; outputs are checked on handshake
  always @(negedge clk) begin
    int v;
    int w;
    for (int k = 0; k < NK; k++) begin
      if (rst) begin
        exp_q[k].delete();
        mx[k] = 0;
        my[k] = 0;
        expect_next[k] = 1'b0;
        prev_hold[k] = 1'b0;
      end else begin
        chk("ready_o", rdy_out[k], !vout[k] || rdy_in[k]);
        if (expect_next[k]) chk("latency", vout[k], 1);
        if (prev_hold[k]) begin
          chk("hold_valid", vout[k], 1);
          chk("hold_data", dout[k], prev_data[k]);
        end
        if (vout[k] && rdy_in[k]) begin
          chk("result_expected", exp_q[k].size() > 0, 1);
          if (exp_q[k].size() > 0) begin
            w = exp_q[k].pop_front();
            chk("data", dout[k], w);
            got_q[k].push_back(int'($signed(dout[k])));
          end
        end
        prev_hold[k] = vout[k] & ~rdy_in[k];
        prev_data[k] = int'($signed(dout[k]));
        expect_next[k] = 1'b0;
        if (vin[k] && rdy_out[k]) begin
          v = relu(int'($signed(din[k])));
          row_buf[k][my[k] % 2][mx[k]] = v;
          if ((mx[k] % 2 == 1) && (my[k] % 2 == 1) &&
              (mx[k] / 2 < lw_of(k) / 2) && (my[k] / 2 < lc_of(k) / 2)) begin
            exp_q[k].push_back(max2(max2(row_buf[k][0][mx[k]-1], row_buf[k][0][mx[k]]),
                                    max2(row_buf[k][1][mx[k]-1], v)));
            expect_next[k] = 1'b1;
          end
          if (mx[k] == lw_of(k) - 1) begin
            mx[k] = 0;
            my[k] = (my[k] == lc_of(k) - 1) ? 0 : my[k] + 1;
          end else begin
            mx[k] = mx[k] + 1;
          end
        end
      end
    end
  end

  task automatic send_range(int k, int mode, int first, int last, bit rv, bit rr);
    int i;
    int guard;
    int val;
    bit fired;
    i = first;
    guard = 0;
    val = gen(mode, i);
    while (i < last) begin
      vin[k]    = rv ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy_in[k] = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
      din[k]    = val;
      @(negedge clk);
      fired = vin[k] & rdy_out[k];
      @(posedge clk);
      #1;
      if (fired) begin
        i++;
        val = gen(mode, i);
      end
      guard++;
      if (guard > 80000) begin
        chk("input_timeout", i, last);
        break;
      end
    end
    vin[k] = 1'b0;
  endtask

  task automatic idle(int n);
    vin = 3'b000;
    rdy_in = 3'b111;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_log(int k, string name, int e0, int e1, int e2, int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, got_q[k].size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < got_q[k].size()) chk(name, got_q[k][j], e[j]);
    end
  endtask

  initial begin
    rst = 1'b1;
    vin = 3'b000;
    rdy_in = 3'b111;
    din = '0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      chk("reset_valid_o", vout[k], 0);
      chk("reset_data_o", dout[k], 0);
      chk("reset_ready_o", rdy_out[k], 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 4x4 ramp
    got_q[0].delete();
    send_range(0, 0, 0, 16, 1'b0, 1'b0);
    idle(4);
    check_log(0, "ramp4", 5, 7, 13, 15);

    // 4x4 all negative
    got_q[0].delete();
    send_range(0, 1, 0, 16, 1'b0, 1'b0);
    idle(4);
`ifdef MAXPOOL2D_RELU_EN
    check_log(0, "neg4", 0, 0, 0, 0);
`else
    check_log(0, "neg4", -11, -9, -3, -1);
`endif

    // 5x5 odd dimensions, two frames back to back
    got_q[1].delete();
    send_range(1, 0, 0, 25, 1'b0, 1'b0);
    send_range(1, 0, 0, 25, 1'b0, 1'b0);
    idle(4);
    chk("odd5_count", got_q[1].size(), 8);
    if (got_q[1].size() >= 8) begin
      for (int f = 0; f < 2; f++) begin
        chk("odd5_a", got_q[1][4*f+0], 6);
        chk("odd5_b", got_q[1][4*f+1], 8);
        chk("odd5_c", got_q[1][4*f+2], 16);
        chk("odd5_d", got_q[1][4*f+3], 18);
      end
    end

    // Backpressure with the first result held
    got_q[0].delete();
    send_range(0, 0, 0, 6, 1'b0, 1'b0);
    rdy_in[0] = 1'b0;
    vin[0] = 1'b1;
    din[0] = 32'd6;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_o", rdy_out[0], 0);
      chk("bp_valid_o", vout[0], 1);
      chk("bp_data_o", dout[0], 5);
    end
    @(posedge clk);
    #1;
    send_range(0, 0, 6, 16, 1'b0, 1'b0);
    idle(4);
    check_log(0, "bp4", 5, 7, 13, 15);

    // Reset in the middle of a frame
    send_range(0, 0, 0, 6, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid_o", vout[0], 0);
    @(posedge clk);
    #1;
    got_q[0].delete();
    send_range(0, 0, 0, 16, 1'b0, 1'b0);
    idle(4);
    check_log(0, "rst4", 5, 7, 13, 15);

    // Full-size frame with random data and random handshakes
    got_q[2].delete();
    send_range(2, 2, 0, 158 * 118, 1'b1, 1'b1);
    idle(20);
    chk("rand_count", got_q[2].size(), 79 * 59);

    for (int k = 0; k < NK; k++) chk("leftover", exp_q[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
